// File: rtl/flexbex_ibex_fetch_prefetch.sv
// Instruction prefetch buffer: word fetches into a small FIFO, with 16-bit realignment so each
// delivered instruction starts at the current PC.
module flexbex_ibex_fetch_prefetch #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;
  state_e state_q, state_d;

  logic [31:0]     fifo_q [DEPTH];
  logic [31:0]     fifo_d [DEPTH];
  logic [CntW-1:0] count_q, count_d, count_after, wr_idx;
  logic [31:0]     fetch_addr_q, fetch_addr_d, req_addr_q, req_addr_d, pc_q, pc_d;
  logic            discard_q, discard_d;
  logic            push, pop, issue, compressed, head_unc;
  logic [31:0]     head, next, pc_next;
  logic            unused_addr_bit;

  assign unused_addr_bit = addr_i[0];

  assign head     = fifo_q[0];
  assign next     = fifo_q[1];
  assign head_unc = head[17:16] == 2'b11;

  // An uncompressed instruction at a halfword offset straddles head and next.
  assign valid_o    = (pc_q[1] && head_unc) ? (count_q >= CntW'(2)) : (count_q != '0);
  assign rdata_o    = pc_q[1] ? {next[15:0], head[31:16]} : head;
  assign compressed = rdata_o[1:0] != 2'b11;
  assign pc_next    = pc_q + (compressed ? 32'd2 : 32'd4);
  assign addr_o     = pc_q;

  assign pop  = valid_o & ready_i & ~branch_i & (pc_next[31:2] != pc_q[31:2]);
  assign push = (state_q == StWaitRvalid) & instr_rvalid_i & ~discard_q & ~branch_i;
  assign count_after = count_q - {{(CntW-1){1'b0}}, pop} + {{(CntW-1){1'b0}}, push};
  assign wr_idx      = count_q - {{(CntW-1){1'b0}}, pop};

  always_comb begin
    fifo_d = fifo_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) fifo_d[i] = fifo_q[i+1];
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CntW'(i) == wr_idx) fifo_d[i] = instr_rdata_i;
      end
    end
    count_d = branch_i ? '0 : count_after;
  end

  always_comb begin
    state_d      = state_q;
    instr_req_o  = 1'b0;
    issue        = 1'b0;
    discard_d    = discard_q;
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    unique case (state_q)
      StIdle: begin
        if (req_i && !branch_i && count_q < DepthC) issue = 1'b1;
      end
      StWaitGnt: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) state_d = StWaitRvalid;
      end
      StWaitRvalid: begin
        if (instr_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = StIdle;
          if (req_i && !branch_i && count_after < DepthC) issue = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      instr_req_o = 1'b1;
      req_addr_d  = fetch_addr_q;
      state_d     = instr_gnt_i ? StWaitRvalid : StWaitGnt;
    end
    // After a redirect during WAIT_GNT, fetch_addr already holds the new target.
    if (instr_req_o && instr_gnt_i && !(state_q == StWaitGnt && discard_q)) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
    if (branch_i) begin
      fetch_addr_d = {addr_i[31:2], 2'b00};
      discard_d    = state_d != StIdle;
    end
  end

  assign instr_addr_o = (state_q == StWaitGnt) ? req_addr_q : fetch_addr_q;
  assign busy_o       = (state_q != StIdle) | instr_req_o;

  always_comb begin
    pc_d = pc_q;
    if (branch_i)                pc_d = {addr_i[31:1], 1'b0};
    else if (valid_o && ready_i) pc_d = pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      fetch_addr_q <= '0;
      req_addr_q   <= '0;
      pc_q         <= '0;
      discard_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      req_addr_q   <= req_addr_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      fifo_q       <= fifo_d;
    end
  end
endmodule

// File: tb/tb_flexbex_ibex_fetch_prefetch.sv
// Directed bench for the prefetch buffer with a simple instruction memory model.
module tb_flexbex_ibex_fetch_prefetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, branch_i, ready_i;
  logic [31:0] addr_i;
  logic        valid_o;
  logic [31:0] rdata_o, addr_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [logic [31:0]];
  logic        gnt_en;
  int          rv_lat;
  logic        rv_pend;
  int          rv_wait;
  logic [31:0] rv_addr;
  logic [31:0] gnt_q[$];
  logic [31:0] out_addr_q[$];
  logic [31:0] out_data_q[$];

  always #5 clk = ~clk;

  flexbex_ibex_fetch_prefetch #(.DEPTH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .rdata_o        (rdata_o),
    .addr_o         (addr_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0003;
  endfunction

  // One clock: memory responds, handshakes are logged, returns 1 time unit after the edge.
  task automatic cycle();
    logic        got_gnt;
    logic [31:0] gaddr;
    @(negedge clk);
    instr_rvalid_i = rv_pend && (rv_wait == 0);
    instr_rdata_i  = instr_rvalid_i ? mem_word(rv_addr) : 32'hDEAD_BEEF;
    #1;
    instr_gnt_i = instr_req_o & gnt_en;
    #1;
    got_gnt = instr_gnt_i;
    gaddr   = instr_addr_o;
    if (got_gnt) gnt_q.push_back(gaddr);
    if (valid_o && ready_i && !branch_i) begin
      out_addr_q.push_back(addr_o);
      out_data_q.push_back(rdata_o);
    end
    @(posedge clk);
    #1;
    if (instr_rvalid_i) rv_pend = 1'b0;
    else if (rv_pend) rv_wait--;
    if (got_gnt) begin
      rv_pend = 1'b1;
      rv_wait = rv_lat - 1;
      rv_addr = gaddr;
    end
    instr_rvalid_i = 1'b0;
    instr_gnt_i    = 1'b0;
  endtask

  task automatic clear_logs();
    gnt_q.delete();
    out_addr_q.delete();
    out_data_q.delete();
  endtask

  task automatic drain();
    req_i  = 1'b0;
    gnt_en = 1'b1;
    repeat (6) cycle();
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_i = 1'b1;
    addr_i   = a;
    cycle();
    branch_i = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    checks++;
    if (instr_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", instr_req_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", valid_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", busy_o);
    end
    checks++;
    if (addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", addr_o);
    end
    checks++;
    if (instr_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_iaddr: got %h expected 0", instr_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    // Hold a request ungranted, then reset in the middle of it.
    gnt_en = 1'b0;
    req_i  = 1'b1;
    do_branch(32'h0000_0500);
    cycle();
    req_i = 1'b0;
    cycle();
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h500 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_req: got req=%b addr=%h busy=%b expected req=1 addr=00000500 busy=1",
               instr_req_o, instr_addr_o, busy_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({instr_req_o, valid_o, busy_o} !== 3'b000 || addr_o !== 32'h0 || instr_addr_o !== 32'h0)
    begin
      errors++;
      $display("FAIL mid_reset: got req=%b valid=%b busy=%b addr=%h iaddr=%h expected all 0",
               instr_req_o, valid_o, busy_o, addr_o, instr_addr_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr_gnt_i = (i % 2 == 1);
      #1;
      checks++;
      if ({instr_req_o, valid_o, busy_o} !== 3'b000 || addr_o !== 32'h0 ||
          instr_addr_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_gnt_toggle: got req=%b valid=%b busy=%b addr=%h iaddr=%h exp 0",
                 instr_req_o, valid_o, busy_o, addr_o, instr_addr_o);
      end
    end
    @(negedge clk);
    rst         = 1'b0;
    instr_gnt_i = 1'b0;
    rv_pend     = 1'b0;
    gnt_en      = 1'b1;
    clear_logs();
  endtask

  task automatic test_aligned();
    logic [31:0] got;
    drain();
    mem[32'h100] = 32'h0000_0013;
    mem[32'h104] = 32'h0010_0093;
    req_i   = 1'b1;
    ready_i = 1'b1;
    do_branch(32'h0000_0100);
    repeat (8) cycle();
    got = (out_addr_q.size() > 0) ? out_addr_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h100) begin
      errors++; $display("FAIL aligned_addr0: got %h expected 00000100", got);
    end
    got = (out_data_q.size() > 0) ? out_data_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h0000_0013) begin
      errors++; $display("FAIL aligned_data0: got %h expected 00000013", got);
    end
    got = (out_addr_q.size() > 1) ? out_addr_q[1] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h104) begin
      errors++; $display("FAIL aligned_addr1: got %h expected 00000104", got);
    end
    got = (out_data_q.size() > 1) ? out_data_q[1] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h0010_0093) begin
      errors++; $display("FAIL aligned_data1: got %h expected 00100093", got);
    end
    for (int i = 0; i < 3; i++) begin
      got = (gnt_q.size() > i) ? gnt_q[i] : 32'hFFFF_FFFF;
      checks++;
      if (got !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL fetch_addr%0d: got %h expected %h", i, got, 32'h100 + 4 * i);
      end
    end
  endtask

  task automatic test_compressed_offset();
    logic [31:0] got;
    drain();
    mem[32'h100] = 32'h4501_0001;
    mem[32'h104] = 32'h0000_0093;
    req_i = 1'b1;
    do_branch(32'h0000_0102);
    repeat (8) cycle();
    got = (out_addr_q.size() > 0) ? out_addr_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h102) begin
      errors++; $display("FAIL c_addr0: got %h expected 00000102", got);
    end
    got = (out_data_q.size() > 0) ? out_data_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got[15:0] !== 16'h4501) begin
      errors++; $display("FAIL c_data0: got %h expected 4501", got[15:0]);
    end
    got = (out_addr_q.size() > 1) ? out_addr_q[1] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h104) begin
      errors++; $display("FAIL c_addr1: got %h expected 00000104", got);
    end
    got = (out_data_q.size() > 1) ? out_data_q[1] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h0000_0093) begin
      errors++; $display("FAIL c_data1: got %h expected 00000093", got);
    end
  endtask

  task automatic test_straddle();
    logic [31:0] got;
    drain();
    mem[32'h200] = 32'h0093_0001;
    mem[32'h204] = 32'h0000_0010;
    req_i = 1'b1;
    do_branch(32'h0000_0202);
    cycle();
    cycle();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL straddle_wait: got valid=%b expected 0", valid_o);
    end
    cycle();
    checks++;
    if (valid_o !== 1'b1 || rdata_o !== 32'h0010_0093 || addr_o !== 32'h202) begin
      errors++;
      $display("FAIL straddle_out: got valid=%b data=%h addr=%h expected 1 00100093 00000202",
               valid_o, rdata_o, addr_o);
    end
    repeat (3) cycle();
    got = (out_addr_q.size() > 1) ? out_addr_q[1] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h206) begin
      errors++; $display("FAIL straddle_next: got %h expected 00000206", got);
    end
  endtask

  task automatic test_branch_discard();
    logic [31:0] got;
    drain();
    mem[32'h200] = 32'h1111_1113;
    mem[32'h300] = 32'h3333_3313;
    rv_lat = 3;
    req_i  = 1'b1;
    do_branch(32'h0000_0200);
    cycle();
    checks++;
    if (busy_o !== 1'b1 || instr_req_o !== 1'b0) begin
      errors++; $display("FAIL wait_rvalid: got busy=%b req=%b expected 1 0", busy_o, instr_req_o);
    end
    do_branch(32'h0000_0300);
    repeat (14) cycle();
    got = (out_addr_q.size() > 0) ? out_addr_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h300) begin
      errors++; $display("FAIL discard_addr: got %h expected 00000300", got);
    end
    got = (out_data_q.size() > 0) ? out_data_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h3333_3313) begin
      errors++; $display("FAIL discard_data: got %h expected 33333313", got);
    end
    got = (gnt_q.size() > 0) ? gnt_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (got !== 32'h300) begin
      errors++; $display("FAIL discard_refetch: got %h expected 00000300", got);
    end
    rv_lat = 1;
  endtask

  task automatic test_full();
    logic [31:0] got;
    drain();
    ready_i = 1'b0;
    req_i   = 1'b1;
    do_branch(32'h0000_0400);
    repeat (12) cycle();
    checks++;
    if (gnt_q.size() !== 3) begin
      errors++; $display("FAIL full_grants: got %0d expected 3", gnt_q.size());
    end
    checks++;
    if (instr_req_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b1 || addr_o !== 32'h400) begin
      errors++;
      $display("FAIL full_idle: got req=%b busy=%b valid=%b addr=%h expected 0 0 1 00000400",
               instr_req_o, busy_o, valid_o, addr_o);
    end
    gnt_q.delete();
    ready_i = 1'b1;
    cycle();
    ready_i = 1'b0;
    repeat (10) cycle();
    got = (out_addr_q.size() > 0) ? out_addr_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (out_addr_q.size() !== 1 || got !== 32'h400) begin
      errors++;
      $display("FAIL full_pop: got %0d pops addr=%h expected 1 pop 00000400", out_addr_q.size(), got);
    end
    got = (gnt_q.size() > 0) ? gnt_q[0] : 32'hFFFF_FFFF;
    checks++;
    if (gnt_q.size() !== 1 || got !== 32'h40C) begin
      errors++;
      $display("FAIL full_refill: got %0d grants addr=%h expected 1 at 0000040c", gnt_q.size(), got);
    end
    checks++;
    if (instr_req_o !== 1'b0 || addr_o !== 32'h404) begin
      errors++;
      $display("FAIL full_after: got req=%b addr=%h expected 0 00000404", instr_req_o, addr_o);
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_i          = 1'b0;
    branch_i       = 1'b0;
    ready_i        = 1'b0;
    addr_i         = 32'h0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'h0;
    gnt_en         = 1'b1;
    rv_lat         = 1;
    rv_pend        = 1'b0;
    rv_wait        = 0;
    rv_addr        = 32'h0;
    #1;
    test_reset();
    test_aligned();
    test_compressed_offset();
    test_straddle();
    test_branch_discard();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
